// File: rtl/ml_accel_seq_if.sv
// Host-side handshake bundle for the tile sequencer.
// master = host driving job control, slave = the sequencer.
interface ml_accel_seq_if #(
  parameter int unsigned TILE_W = 8
);
  logic              start;
  logic [TILE_W-1:0] num_tiles;
  logic              abort;
  logic              data_ready;
  logic              done;
  logic              ack;
  logic              idle;
  logic              busy;
  logic              compute_en;
  logic [TILE_W-1:0] tile_idx;
  logic              irq;
  logic              error;
  logic [2:0]        state;

  modport master (
    output start, num_tiles, abort, data_ready, done, ack,
    input  idle, busy, compute_en, tile_idx, irq, error, state
  );

  modport slave (
    input  start, num_tiles, abort, data_ready, done, ack,
    output idle, busy, compute_en, tile_idx, irq, error, state
  );
endinterface

// File: rtl/ml_accel_seq.sv
// Tile job sequencer: walks a job through LOAD/COMPUTE per tile with a per-phase
// watchdog, then parks in DONE or ERROR until the host acknowledges.
module ml_accel_seq #(
  parameter int unsigned TILE_W  = 8,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned TO_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  ml_accel_seq_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_DONE    = 3'd3,
    S_ERROR   = 3'd4
  } state_e;

  localparam logic [TO_W-1:0]   WD_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TILE_W-1:0] TILE_ONE = TILE_W'(1);

  state_e            state_q, state_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [TILE_W-1:0] num_q, num_d;
  logic [TO_W-1:0]   wd_q, wd_d;

  logic idle_q, idle_d;
  logic busy_q, busy_d;
  logic cen_q, cen_d;
  logic irq_q, irq_d;
  logic err_q, err_d;

  logic wd_expired_c;
  logic last_tile_c;

  assign wd_expired_c = (wd_q == WD_LAST);
  assign last_tile_c  = (tile_q == (num_q - TILE_ONE));

  // State, counters and decoded flags all update together so outputs stay Moore.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tile_q  <= '0;
      num_q   <= '0;
      wd_q    <= '0;
      idle_q  <= 1'b1;
      busy_q  <= 1'b0;
      cen_q   <= 1'b0;
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      num_q   <= num_d;
      wd_q    <= wd_d;
      idle_q  <= idle_d;
      busy_q  <= busy_d;
      cen_q   <= cen_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
    end
  end

  // Next state; abort outranks phase events, which outrank watchdog expiry.
  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    num_d   = num_q;
    wd_d    = wd_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.num_tiles != '0)) begin
          state_d = S_LOAD;
          num_d   = bus.num_tiles;
          tile_d  = '0;
          wd_d    = '0;
        end
      end

      S_LOAD: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          tile_d  = '0;
          wd_d    = '0;
        end else if (bus.data_ready) begin
          state_d = S_COMPUTE;
          wd_d    = '0;
        end else if (wd_expired_c) begin
          state_d = S_ERROR;
          wd_d    = '0;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end

      S_COMPUTE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          tile_d  = '0;
          wd_d    = '0;
        end else if (bus.done) begin
          wd_d = '0;
          if (last_tile_c) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            tile_d  = tile_q + TILE_ONE;
          end
        end else if (wd_expired_c) begin
          state_d = S_ERROR;
          wd_d    = '0;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end

      S_DONE: begin
        if (bus.ack) begin
          state_d = S_IDLE;
          tile_d  = '0;
        end
      end

      S_ERROR: begin
        if (bus.ack || bus.abort) begin
          state_d = S_IDLE;
          tile_d  = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        tile_d  = '0;
        wd_d    = '0;
      end
    endcase
  end

  // Flags are decoded from the next state so they register alongside it.
  always_comb begin
    idle_d = (state_d == S_IDLE);
    busy_d = (state_d == S_LOAD) || (state_d == S_COMPUTE);
    cen_d  = (state_d == S_COMPUTE);
    irq_d  = (state_d == S_DONE);
    err_d  = (state_d == S_ERROR);
  end

  assign bus.idle       = idle_q;
  assign bus.busy       = busy_q;
  assign bus.compute_en = cen_q;
  assign bus.irq        = irq_q;
  assign bus.error      = err_q;
  assign bus.tile_idx   = tile_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_ml_accel_seq.sv
// Self-checking bench for ml_accel_seq: directed vector table, corner sequences
// and randomized traffic against a job-level reference model.
module tb_ml_accel_seq;

  localparam int unsigned TILE_W  = 8;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned TO_W    = 16;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  ml_accel_seq_if #(.TILE_W(TILE_W)) bus ();

  ml_accel_seq #(
    .TILE_W (TILE_W),
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic       s;
    logic [7:0] n;
    logic       a;
    logic       dr;
    logic       dn;
    logic       ak;
    int         st;
    int         tl;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Job-level model: phase numbers follow the published state encoding.
  int m_phase, m_tile, m_total, m_cycles;

  int cen_windows;
  logic cen_prev;
  logic irq_seen, busy_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input int st, input int tl);
    logic [4:0] exp_f;
    exp_f = {st == 0, (st == 1) || (st == 2), st == 2, st == 3, st == 4};
    chk("state", 32'(bus.state), 32'(st));
    chk("tile_idx", 32'(bus.tile_idx), 32'(tl));
    chk("flags", 32'({bus.idle, bus.busy, bus.compute_en, bus.irq, bus.error}), 32'(exp_f));
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_tile   = 0;
    m_total  = 0;
    m_cycles = 0;
  endtask

  // One clock of the job rules, using the inputs presented at this edge.
  task automatic model_step();
    case (m_phase)
      0: if (bus.start && bus.num_tiles != 0) begin
           m_total = int'(bus.num_tiles); m_tile = 0; m_cycles = 0; m_phase = 1;
         end
      1, 2: begin
        if (bus.abort) begin
          m_phase = 0; m_tile = 0; m_cycles = 0;
        end else if (m_phase == 1 && bus.data_ready) begin
          m_phase = 2; m_cycles = 0;
        end else if (m_phase == 2 && bus.done) begin
          m_cycles = 0;
          if (m_tile + 1 < m_total) begin
            m_tile++; m_phase = 1;
          end else begin
            m_phase = 3;
          end
        end else begin
          m_cycles++;
          if (m_cycles == TIMEOUT) m_phase = 4;
        end
      end
      3: if (bus.ack) begin m_phase = 0; m_tile = 0; end
      default: if (bus.ack || bus.abort) begin m_phase = 0; m_tile = 0; end
    endcase
  endtask

  task automatic drive(input logic s, input logic [7:0] n, input logic a,
                       input logic dr, input logic dn, input logic ak);
    bus.start      = s;
    bus.num_tiles  = n;
    bus.abort      = a;
    bus.data_ready = dr;
    bus.done       = dn;
    bus.ack        = ak;
  endtask

  task automatic cyc(input logic s, input logic [7:0] n, input logic a,
                     input logic dr, input logic dn, input logic ak);
    drive(s, n, a, dr, dn, ak);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(m_phase, m_tile);
    if (bus.compute_en && !cen_prev) cen_windows++;
    cen_prev = bus.compute_en;
    if (bus.irq) irq_seen = 1'b1;
    if (bus.busy) busy_seen = 1'b1;
  endtask

  task automatic idle_cyc();
    cyc(0, 8'd0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(0, 8'd0, 0, 0, 0, 0);
    reset_n = 1'b0;
    model_reset();
    #12;
    check_outputs(0, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  vec_t tbl[16];
  logic quiet;

  initial begin
    tbl[0]  = '{1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
    tbl[2]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0};
    tbl[3]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1};
    tbl[4]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1};
    tbl[5]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1};
    tbl[6]  = '{1'b1, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1};
    tbl[7]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1};
    tbl[8]  = '{1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1};
    tbl[9]  = '{1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[10] = '{1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
    tbl[11] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[12] = '{1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
    tbl[13] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0};
    tbl[14] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[15] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};

    cen_windows = 0;
    cen_prev    = 1'b0;
    irq_seen    = 1'b0;
    busy_seen   = 1'b0;
    do_reset();

    // Directed vector table with literal expectations.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].s, tbl[i].n, tbl[i].a, tbl[i].dr, tbl[i].dn, tbl[i].ak);
      @(posedge clk);
      model_step();
      #1;
      check_outputs(tbl[i].st, tbl[i].tl);
    end

    // Three-tile job with fixed operand/compute latencies.
    cen_windows = 0;
    cen_prev    = bus.compute_en;
    cyc(1, 8'd3, 0, 0, 0, 0);
    for (int t = 0; t < 3; t++) begin
      chk("job3_tile", 32'(bus.tile_idx), 32'(t));
      idle_cyc();
      cyc(0, 8'd0, 0, 1, 0, 0);
      for (int k = 0; k < 3; k++) idle_cyc();
      cyc(0, 8'd0, 0, 0, 1, 0);
    end
    chk("job3_irq", 32'(bus.irq), 32'd1);
    chk("job3_windows", 32'(cen_windows), 32'd3);
    cyc(0, 8'd0, 0, 0, 0, 1);
    chk("job3_ack_idle", 32'({bus.idle, bus.tile_idx}), 32'({1'b1, 8'd0}));

    // Zero-tile start never leaves IDLE.
    busy_seen = 1'b0;
    for (int k = 0; k < 3; k++) cyc(1, 8'd0, 0, 0, 0, 0);
    chk("zero_tiles_busy", 32'(busy_seen), 32'd0);

    // Stalled LOAD: busy for exactly TIMEOUT cycles, then ERROR.
    cyc(1, 8'd1, 0, 0, 0, 0);
    for (int k = 0; k < int'(TIMEOUT) - 1; k++) idle_cyc();
    chk("wd_still_busy", 32'(bus.state), 32'd1);
    idle_cyc();
    chk("wd_error_state", 32'(bus.state), 32'd4);
    chk("wd_error_flag", 32'(bus.error), 32'd1);
    cyc(0, 8'd0, 0, 0, 0, 1);
    chk("wd_ack_idle", 32'(bus.state), 32'd0);

    // Abort wins over done in COMPUTE.
    irq_seen = 1'b0;
    cyc(1, 8'd2, 0, 0, 0, 0);
    cyc(0, 8'd0, 0, 1, 0, 0);
    cyc(0, 8'd0, 1, 0, 1, 0);
    chk("abort_done_state", 32'(bus.state), 32'd0);
    idle_cyc();
    chk("abort_no_irq", 32'(irq_seen), 32'd0);

    // Done on the final watchdog cycle of the last tile completes the job.
    cyc(1, 8'd1, 0, 0, 0, 0);
    cyc(0, 8'd0, 0, 1, 0, 0);
    for (int k = 0; k < int'(TIMEOUT) - 1; k++) idle_cyc();
    cyc(0, 8'd0, 0, 0, 1, 0);
    chk("late_done_state", 32'(bus.state), 32'd3);
    cyc(0, 8'd0, 0, 0, 0, 1);

    // Largest job: tile_idx climbs to 254 without wrapping.
    cyc(1, 8'd255, 0, 0, 0, 0);
    for (int t = 0; t < 255; t++) begin
      cyc(0, 8'd0, 0, 1, 0, 0);
      cyc(0, 8'd0, 0, 0, 1, 0);
    end
    chk("max_job_state", 32'(bus.state), 32'd3);
    chk("max_job_tile", 32'(bus.tile_idx), 32'd254);
    cyc(0, 8'd0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a COMPUTE cycle.
    cyc(1, 8'd2, 0, 0, 0, 0);
    cyc(0, 8'd0, 0, 1, 0, 0);
    chk("pre_reset_compute", 32'(bus.compute_en), 32'd1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs(0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) idle_cyc();
    chk("post_reset_idle", 32'(bus.state), 32'd0);

    // Randomized traffic against the model, with quiet stretches to hit the watchdog.
    quiet = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      logic s, a, dr, dn, ak;
      logic [7:0] n;
      if ($urandom_range(0, 15) == 0) quiet = ~quiet;
      s  = ($urandom_range(0, 2) == 0);
      n  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
      a  = ($urandom_range(0, 24) == 0);
      dr = !quiet && ($urandom_range(0, 2) == 0);
      dn = !quiet && ($urandom_range(0, 2) == 0);
      ak = ($urandom_range(0, 3) == 0);
      cyc(s, n, a, dr, dn, ak);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
